// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared defaults and filter action type for the GPIO input debounce
package gpio_pkg;

   localparam int GPIO_N_GPIOS = 8;
   localparam int GPIO_CNT_W   = 16;
   localparam logic [GPIO_CNT_W-1:0] GPIO_DEBOUNCE_DEF = 16'd4;

   // What a channel does with its counter and level on the next edge
   typedef enum logic [1:0] {
      ACT_HOLD   = 2'd0,
      ACT_COUNT  = 2'd1,
      ACT_COMMIT = 2'd2
   } filt_act_e;

endpackage

// File: rtl/gpio_debounce_ch.sv
// rtl/gpio_debounce_ch.sv - single-pin 2-FF synchronizer, stability counter and val/chg registers
module gpio_debounce_ch
   import gpio_pkg::*;
#(
   parameter int CNT_W = GPIO_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pin_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] thresh_i,
   output logic             val_o,
   output logic             chg_o
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             sync1_q;
   logic             sync2_q;
   logic             val_q;
   logic             chg_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] th_m1;
   filt_act_e        act;

   // thresh_i of 0 behaves as 1, so the commit point is max(thresh_i,1)-1
   always_comb begin
      th_m1 = '0;
      if (thresh_i != '0) begin
         th_m1 = thresh_i - ONE;
      end
   end

   always_comb begin
      act = ACT_HOLD;
      if (!en_i) begin
         if (sync2_q != val_q) begin
            act = ACT_COMMIT;
         end
      end else if (sync2_q != val_q) begin
         // >= lets a lowered threshold commit immediately on a long-running count
         if (cnt_q >= th_m1) begin
            act = ACT_COMMIT;
         end else begin
            act = ACT_COUNT;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         val_q   <= 1'b0;
         chg_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         case (act)
            ACT_COUNT: begin
               cnt_q <= cnt_q + ONE;
               chg_q <= 1'b0;
            end
            ACT_COMMIT: begin
               val_q <= sync2_q;
               cnt_q <= '0;
               chg_q <= 1'b1;
            end
            default: begin
               cnt_q <= '0;
               chg_q <= 1'b0;
            end
         endcase
      end
   end

   assign val_o = val_q;
   assign chg_o = chg_q;

endmodule

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-pin input conditioning ahead of the GPIO val_i input
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int N_GPIOS = GPIO_N_GPIOS,
   parameter int CNT_W   = GPIO_CNT_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N_GPIOS-1:0] pin_i,
   input  logic [N_GPIOS-1:0] en_i,
   input  logic [CNT_W-1:0]   thresh_i,
   output logic [N_GPIOS-1:0] val_o,
   output logic [N_GPIOS-1:0] chg_o
);

   // Threshold is shared; every channel filters independently
   for (genvar g = 0; g < N_GPIOS; g++) begin : g_ch
      gpio_debounce_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .pin_i    (pin_i[g]),
         .en_i     (en_i[g]),
         .thresh_i (thresh_i),
         .val_o    (val_o[g]),
         .chg_o    (chg_o[g])
      );
   end

endmodule

// File: tb/tb_gpio_debounce.sv
// tb/tb_gpio_debounce.sv - scoreboard bench for gpio_debounce
module tb_gpio_debounce;
   import gpio_pkg::*;

   localparam int N = 8;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] pin;
   logic [N-1:0] en;
   logic [W-1:0] thresh;
   logic [N-1:0] val;
   logic [N-1:0] chg;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int           cyc;
      logic [N-1:0] val;
      logic [N-1:0] chg;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   gpio_debounce #(
      .N_GPIOS (N),
      .CNT_W   (W)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .pin_i    (pin),
      .en_i     (en),
      .thresh_i (thresh),
      .val_o    (val),
      .chg_o    (chg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Edge number is relative to the edge index current when inputs change
   task automatic expect_evt(input int delay, input logic [N-1:0] v, input logic [N-1:0] c);
      exp_t e;
      e.cyc = cyc + delay;
      e.val = v;
      e.chg = c;
      sb.push_back(e);
   endtask

   task automatic check_now(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && chg !== '0) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_chg: cyc %0d val %h chg %h, required no pulse", cyc, val, chg);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc || val !== mon_e.val || chg !== mon_e.chg) begin
               miscompares++;
               $display("FAIL chg_event: cyc %0d val %h chg %h, required cyc %0d val %h chg %h",
                        cyc, val, chg, mon_e.cyc, mon_e.val, mon_e.chg);
            end
         end
      end
   end

   initial begin
      pin    = 8'hFF;
      en     = 8'hFF;
      thresh = GPIO_DEBOUNCE_DEF;
      rst    = 1'b1;
      tick(3);
      check_now("reset_val", val, 8'h00);
      check_now("reset_chg", chg, 8'h00);

      // start-up edge with pins held high through reset
      rst = 1'b0;
      expect_evt(6, 8'hFF, 8'hFF);
      tick(12);
      pin = 8'h00;
      expect_evt(6, 8'h00, 8'hFF);
      tick(12);

      // 3-cycle glitch is rejected
      pin = 8'h01;
      tick(3);
      pin = 8'h00;
      tick(12);
      check_now("glitch_val", val, 8'h00);

      // threshold 4: rise and fall both at E0+5
      pin = 8'h01;
      expect_evt(6, 8'h01, 8'h01);
      tick(12);
      pin = 8'h00;
      expect_evt(6, 8'h00, 8'h01);
      tick(12);

      // pin 1 bypassed, pin 0 filtered with the same 2-cycle pattern
      en = 8'hFD;
      for (int i = 0; i < 4; i++) begin
         pin = (i % 2 == 0) ? 8'h03 : 8'h00;
         expect_evt(3, (i % 2 == 0) ? 8'h02 : 8'h00, 8'h02);
         tick(2);
      end
      tick(8);
      for (int i = 0; i < 4; i++) begin
         pin = (i % 2 == 0) ? 8'h02 : 8'h00;
         expect_evt(3, (i % 2 == 0) ? 8'h02 : 8'h00, 8'h02);
         tick(1);
      end
      tick(8);
      en = 8'hFF;

      // lowering the threshold below the running count commits next edge
      thresh = 16'd10;
      pin = 8'h04;
      tick(7);
      thresh = 16'd3;
      expect_evt(1, 8'h04, 8'h04);
      tick(4);
      thresh = 16'd0;
      pin = 8'h00;
      expect_evt(3, 8'h00, 8'h04);
      tick(6);
      pin = 8'h04;
      expect_evt(3, 8'h04, 8'h04);
      tick(6);

      // asynchronous reset mid-count, then full latency from scratch
      thresh = 16'd10;
      pin = 8'h0C;
      tick(7);
      check_now("pre_reset_val", val, 8'h04);
      #2 rst = 1'b1;
      #1;
      check_now("async_rst_val", val, 8'h00);
      check_now("async_rst_chg", chg, 8'h00);
      tick(2);
      rst = 1'b0;
      expect_evt(12, 8'h0C, 8'h0C);
      tick(16);
      check_now("post_reset_val", val, 8'h0C);

      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL missing_events: %0d pending, required 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
